// File: rtl/gf_mac_serial.sv
// gf_mac_serial -- iterative GF(2^M) multiply-accumulate engine.
//
// Computes P = A*B mod POLY bit-serially, MSB-first (Horner), and optionally
// XORs the product into an internal accumulator. After an operand is
// accepted, the engine takes M RUN cycles, then holds the result in DONE
// until the downstream side accepts it.
//
// Build option:
//   GF_MAC_DIGIT2_EN  when defined, two Horner steps run per RUN cycle, so
//                     the latency drops to ceil(M/2) RUN cycles. Results are
//                     the same as in the one-bit-per-cycle build.
//
// Parameters:
//   M     field width in bits (2..16)
//   POLY  primitive polynomial, M+1 bits, bit M set
//
// Ports:
//   CLK        clock, rising edge
//   RESET      synchronous active-high reset
//   in_valid   operand valid
//   in_ready   engine can accept operands (IDLE)
//   in_a       multiplicand A
//   in_b       multiplier B
//   in_acc     1: result = A*B ^ acc_reg, 0: result = A*B
//   acc_clr    clear accumulator (honoured in IDLE only)
//   out_valid  result valid (DONE)
//   out_ready  downstream accepts result
//   out_p      result
//   busy       high in RUN or DONE
module gf_mac_serial #(
    parameter int unsigned M    = 8,
    parameter logic [M:0]  POLY = 9'h11D
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] in_a,
    input  logic [M-1:0] in_b,
    input  logic         in_acc,
    input  logic         acc_clr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] out_p,
    output logic         busy
);

    localparam int unsigned CW = $clog2(M + 1);

`ifdef GF_MAC_DIGIT2_EN
    // For odd M the counter starts one above the MSB. b_reg carries a zero
    // bit there, and a Horner step on a zero partial with a zero bit keeps it
    // zero, so the first cycle effectively handles bit M-1 on its own.
    localparam int unsigned   STEP      = 2;
    localparam logic [CW-1:0] CNT_START = CW'(M - 1 + (M % 2));
    localparam logic [CW-1:0] CNT_LAST  = CW'(1);
`else
    localparam int unsigned   STEP      = 1;
    localparam logic [CW-1:0] CNT_START = CW'(M - 1);
    localparam logic [CW-1:0] CNT_LAST  = '0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [M-1:0]  a_reg;
    logic [M:0]    b_reg;       // top bit always zero, see CNT_START
    logic          acc_flag;
    logic [M-1:0]  partial;
    logic [M-1:0]  acc_reg;
    logic [CW-1:0] cnt;

    logic [M-1:0]  partial_next;
    logic [M-1:0]  result;

    // Multiply by x modulo POLY.
    function automatic logic [M-1:0] xtime(input logic [M-1:0] v);
        return {v[M-2:0], 1'b0} ^ (v[M-1] ? POLY[M-1:0] : '0);
    endfunction

    // NOTE: every signal driven here gets a value before any condition, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        partial_next = xtime(partial) ^ (b_reg[cnt] ? a_reg : '0);
`ifdef GF_MAC_DIGIT2_EN
        partial_next = xtime(partial_next) ^ (b_reg[cnt - CW'(1)] ? a_reg : '0);
`endif
        result = partial_next ^ (acc_flag ? acc_reg : '0);
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                if (cnt == CNT_LAST) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            acc_flag <= 1'b0;
            partial  <= '0;
            cnt      <= '0;
            acc_reg  <= '0;
            out_p    <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    // The clear lands at the accept edge, and acc_reg is only
                    // read at the end of RUN, so a same-edge op sees zero.
                    if (acc_clr) acc_reg <= '0;
                    if (in_valid) begin
                        a_reg    <= in_a;
                        b_reg    <= {1'b0, in_b};
                        acc_flag <= in_acc;
                        partial  <= '0;
                        cnt      <= CNT_START;
                    end
                end
                RUN: begin
                    partial <= partial_next;
                    cnt     <= cnt - CW'(STEP);
                    if (cnt == CNT_LAST) begin
                        out_p   <= result;
                        acc_reg <= result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf_mac_serial.sv
// Testbench for gf_mac_serial: three instances (M=8, M=4, M=5) share the
// operand bus. Each op is checked against a polynomial long-division model
// of GF(2^M) multiplication, together with the accumulator semantics,
// latency, handshake and reset behaviour.
module tb_gf_mac_serial;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [2:0] in_valid_v;
    logic [2:0] acc_clr_v;
    logic [2:0] in_ready_v;
    logic [2:0] out_valid_v;
    logic [2:0] busy_v;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_acc;
    logic       out_ready;
    logic [7:0] out_p_v [3];
    logic [3:0] p4;
    logic [4:0] p5;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam int   M_OF    [3] = '{8, 4, 5};
    localparam int   POLY_OF [3] = '{32'h11D, 32'h13, 32'h25};
    logic [7:0] acc_m [3];

    always #5 CLK = ~CLK;

    gf_mac_serial u8 (
        .CLK(CLK), .RESET(RESET), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .in_a(in_a), .in_b(in_b), .in_acc(in_acc), .acc_clr(acc_clr_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready), .out_p(out_p_v[0]),
        .busy(busy_v[0])
    );

    gf_mac_serial #(.M(4), .POLY(5'h13)) u4 (
        .CLK(CLK), .RESET(RESET), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .in_a(in_a[3:0]), .in_b(in_b[3:0]), .in_acc(in_acc), .acc_clr(acc_clr_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready), .out_p(p4),
        .busy(busy_v[1])
    );

    gf_mac_serial #(.M(5), .POLY(6'h25)) u5 (
        .CLK(CLK), .RESET(RESET), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .in_a(in_a[4:0]), .in_b(in_b[4:0]), .in_acc(in_acc), .acc_clr(acc_clr_v[2]),
        .out_valid(out_valid_v[2]), .out_ready(out_ready), .out_p(p5),
        .busy(busy_v[2])
    );

    assign out_p_v[1] = {4'b0, p4};
    assign out_p_v[2] = {3'b0, p5};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Carry-less product followed by polynomial long division.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b,
                                          input int m, input int poly);
        logic [31:0] prod;
        prod = '0;
        for (int i = 0; i < m; i++)
            if (b[i]) prod ^= 32'(a) << i;
        for (int i = 2 * m - 2; i >= m; i--)
            if (prod[i]) prod ^= 32'(poly) << (i - m);
        return prod[7:0];
    endfunction

    function automatic int exp_lat(input int m);
`ifdef GF_MAC_DIGIT2_EN
        return (m + 1) / 2;
`else
        return m;
`endif
    endfunction

    // One complete transaction on instance s. hold = cycles of out_ready=0
    // in DONE, with in_valid pulses that must be ignored.
    task automatic op(input int s, input logic [7:0] a_in, input logic [7:0] b_in,
                      input bit acc, input bit clr, input bit clr_run, input int hold);
        logic [7:0] a, b, msk, exp_p;
        int  lat;
        bit  seen;
        msk = 8'((32'd1 << M_OF[s]) - 1);
        a = a_in & msk;
        b = b_in & msk;
        out_ready = (hold == 0);

        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (in_ready_v[s]) begin
                seen = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        check($sformatf("ready_wait[%0d]", s), 32'(seen), 32'd1);

        if (clr) acc_m[s] = '0;
        exp_p = gf_mul(a, b, M_OF[s], POLY_OF[s]) ^ (acc ? acc_m[s] : 8'h00);
        acc_m[s] = exp_p;

        in_a = a; in_b = b; in_acc = acc; acc_clr_v[s] = clr; in_valid_v[s] = 1'b1;
        @(negedge CLK);
        in_valid_v[s] = 1'b0;
        acc_clr_v[s]  = clr_run;
        in_a = 8'($urandom); in_b = 8'($urandom); in_acc = 1'($urandom);
        check($sformatf("run_busy[%0d]", s), 32'(busy_v[s]), 32'd1);
        check($sformatf("run_ready[%0d]", s), 32'(in_ready_v[s]), 32'd0);

        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (!out_valid_v[s] && lat < 30);
        acc_clr_v[s] = 1'b0;
        check($sformatf("latency[%0d]", s), 32'(lat), 32'(exp_lat(M_OF[s])));
        check($sformatf("result[%0d] %0h*%0h", s, a, b), 32'(out_p_v[s]), 32'(exp_p));

        for (int h = 1; h <= hold; h++) begin
            in_valid_v[s] = h[0];
            in_a = 8'($urandom); in_b = 8'($urandom);
            @(negedge CLK);
            check($sformatf("hold_valid[%0d]", s), 32'(out_valid_v[s]), 32'd1);
            check($sformatf("hold_p[%0d]", s), 32'(out_p_v[s]), 32'(exp_p));
            check($sformatf("hold_ready[%0d]", s), 32'(in_ready_v[s]), 32'd0);
        end
        in_valid_v[s] = 1'b0;
        out_ready = 1'b1;
        @(negedge CLK);
        check($sformatf("back_idle_ready[%0d]", s), 32'(in_ready_v[s]), 32'd1);
        check($sformatf("back_idle_valid[%0d]", s), 32'(out_valid_v[s]), 32'd0);
        check($sformatf("back_idle_busy[%0d]", s), 32'(busy_v[s]), 32'd0);
    endtask

    initial begin
        RESET = 1'b1;
        in_valid_v = '0; acc_clr_v = '0;
        in_a = '0; in_b = '0; in_acc = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) acc_m[i] = '0;
        repeat (3) @(negedge CLK);
        check("rst_in_ready", 32'(in_ready_v[0]), 32'd1);
        check("rst_out_valid", 32'(out_valid_v[0]), 32'd0);
        check("rst_out_p", 32'(out_p_v[0]), 32'd0);
        check("rst_busy", 32'(busy_v[0]), 32'd0);
        RESET = 1'b0;
        @(negedge CLK);

        // Basic products.
        op(0, 8'h02, 8'h80, 1'b0, 1'b0, 1'b0, 0);
        op(0, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 0);
        op(0, 8'h03, 8'h03, 1'b0, 1'b0, 1'b0, 0);
        op(0, 8'hA7, 8'h01, 1'b0, 1'b0, 1'b0, 0);
        op(0, 8'h5C, 8'h00, 1'b0, 1'b0, 1'b0, 0);

        // MAC sequence, then a RUN-time acc_clr pulse that must be ignored.
        op(0, 8'h02, 8'h80, 1'b1, 1'b1, 1'b0, 0);
        check("mac1_is_1d", 32'(acc_m[0]), 32'h1D);
        op(0, 8'h03, 8'h03, 1'b1, 1'b0, 1'b0, 0);
        op(0, 8'h03, 8'h03, 1'b0, 1'b0, 1'b0, 0);
        op(0, 8'h11, 8'h22, 1'b1, 1'b0, 1'b1, 0);

        // Backpressure.
        op(0, 8'h9E, 8'h4B, 1'b1, 1'b0, 1'b0, 5);

        // Reset three cycles into RUN.
        in_a = 8'h37; in_b = 8'hC5; in_acc = 1'b1; in_valid_v[0] = 1'b1;
        @(negedge CLK);
        in_valid_v[0] = 1'b0;
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) acc_m[i] = '0;
        check("abort_in_ready", 32'(in_ready_v[0]), 32'd1);
        check("abort_out_valid", 32'(out_valid_v[0]), 32'd0);
        check("abort_busy", 32'(busy_v[0]), 32'd0);
        op(0, 8'h02, 8'h80, 1'b1, 1'b0, 1'b0, 0);

        // Small fields.
        op(1, 8'h08, 8'h02, 1'b0, 1'b0, 1'b0, 0);
        op(1, 8'h0F, 8'h0F, 1'b0, 1'b0, 1'b0, 0);
        op(2, 8'h1F, 8'h13, 1'b0, 1'b0, 1'b0, 0);

        // Random mix across all instances.
        for (int i = 0; i < 40; i++) begin
            op($urandom_range(0, 2), 8'($urandom), 8'($urandom), 1'($urandom),
               ($urandom_range(0, 3) == 0), 1'($urandom), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
